// File: rtl/nco_pkg.sv
// Shared constants, types and the elaboration-time ROM generator for the
// phasor NCO. The quarter-wave table is computed here so the ROM module and
// any model of it agree on one definition of L[i].
package nco_pkg;

    localparam int PHASE_W = 24;             // one full turn = 2^PHASE_W
    localparam int LUT_AW  = 10;             // quarter-wave ROM address bits
    localparam int OUT_W   = 12;             // signed output sample width
    localparam int AMP     = 2047;           // peak amplitude, <= 2^(OUT_W-1)-1

    localparam int  LUT_N  = 1 << LUT_AW;    // ROM depth
    localparam int  LUT_DW = OUT_W - 1;      // ROM holds magnitudes only
    localparam real PI     = 3.14159265358979323846;

    typedef logic signed [OUT_W-1:0]  sample_t;
    typedef logic        [LUT_DW-1:0] lut_word_t;
    typedef logic        [LUT_AW-1:0] lut_addr_t;
    typedef logic        [PHASE_W-1:0] phase_t;

    // Top two angle bits select the quadrant of the turn.
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_t;

    // L[i] = round(AMP * sin(pi/2 * (i + 0.5) / N)). The half-step offset
    // keeps the table symmetric so L[~a] is exactly the cosine partner of
    // L[a] and no entry sits on the a=0 / a=N seam. Values are positive,
    // so adding 0.5 before truncation is a true round-to-nearest.
    function automatic lut_word_t lut_val(input int i);
        real x;
        x = real'(AMP) * $sin(PI / 2.0 * (real'(i) + 0.5) / real'(LUT_N));
        return lut_word_t'($rtoi(x + 0.5));
    endfunction

    // Zero-extend a ROM magnitude to a signed sample and optionally negate.
    // AMP never reaches the most negative code, so negation cannot overflow.
    function automatic sample_t signed_mag(input lut_word_t mag, input logic neg);
        sample_t s;
        s = sample_t'({1'b0, mag});
        return neg ? -s : s;
    endfunction

endpackage : nco_pkg

// File: rtl/sine_qlut.sv
// Quarter-wave sine ROM with two synchronous read ports. Port A returns
// L[a] and port B returns L[~a]; together they give sin and cos magnitudes
// for any angle inside a quadrant. The data path carries no reset.
module sine_qlut
    import nco_pkg::*;
(
    input  logic      clk,
    input  logic      rd_en,
    input  lut_addr_t addr_a,
    input  lut_addr_t addr_b,
    output lut_word_t data_a,
    output lut_word_t data_b
);

    lut_word_t rom [LUT_N];
    lut_word_t data_a_reg;
    lut_word_t data_b_reg;

    // Table contents are constants evaluated at elaboration.
    genvar gi;
    generate
        for (gi = 0; gi < LUT_N; gi++) begin : g_rom
            assign rom[gi] = lut_val(gi);
        end
    endgenerate

    // Registered reads; rd_en lets the owning pipeline stall the outputs.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            data_a_reg <= rom[addr_a];
            data_b_reg <= rom[addr_b];
        end
    end

    assign data_a = data_a_reg;
    assign data_b = data_b_reg;

endmodule : sine_qlut

// File: rtl/phasor_nco.sv
// Numerically controlled oscillator producing a unit phasor (cos on the
// real output, sin on the imaginary output) over a valid/ready stream.
// Pipeline: stage 0 = angle register, stage 1 = ROM read, stage 2 =
// quadrant folding into the output registers. A single advance signal
// stalls every stage together whenever the output is held.
module phasor_nco
    import nco_pkg::*;
(
    input  logic    ap_clk,
    input  logic    ap_rst_n,
    input  logic    en,
    input  logic    load,
    input  phase_t  phase_inc,
    input  phase_t  phase_off,
    output logic    ph_valid,
    input  logic    ph_ready,
    output sample_t ph_real,
    output sample_t ph_imag
);

    // Phase accumulator and stage 0.
    phase_t    acc_reg;
    phase_t    s0_angle_reg;
    logic      s0_valid_reg;

    // Stage 1: quadrant travels alongside the ROM read.
    quadrant_t s1_q_reg;
    logic      s1_valid_reg;

    // Stage 2: output registers.
    logic      ph_valid_reg;
    sample_t   ph_real_reg;
    sample_t   ph_imag_reg;

    logic      advance;
    logic      issue;
    phase_t    angle_next;
    lut_addr_t lut_addr;
    lut_word_t lut_sin;      // L[a]
    lut_word_t lut_cos;      // L[~a]
    sample_t   real_next;
    sample_t   imag_next;

    // The pipeline moves whenever the output slot is empty or being taken.
    assign advance    = !ph_valid_reg || ph_ready;
    assign issue      = en && advance && !load;
    assign angle_next = acc_reg + phase_off;
    assign lut_addr   = s0_angle_reg[PHASE_W-3 -: LUT_AW];

    // The bits below the ROM address are truncated without dither.
    logic unused_angle_lsbs;
    assign unused_angle_lsbs = ^s0_angle_reg[PHASE_W-LUT_AW-3:0];

    // Accumulator and stage 0: load clears, otherwise issue on en when free.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_reg      <= '0;
            s0_angle_reg <= '0;
            s0_valid_reg <= 1'b0;
        end else if (load) begin
            acc_reg      <= '0;
            s0_valid_reg <= 1'b0;
        end else if (advance) begin
            s0_valid_reg <= en;
            if (issue) begin
                s0_angle_reg <= angle_next;
                acc_reg      <= acc_reg + phase_inc;
            end
        end
    end

    sine_qlut u_lut (
        .clk    (ap_clk),
        .rd_en  (advance),
        .addr_a (lut_addr),
        .addr_b (~lut_addr),
        .data_a (lut_sin),
        .data_b (lut_cos)
    );

    // Stage 1: carry quadrant and valid in step with the ROM read.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_q_reg     <= QUAD_0;
            s1_valid_reg <= 1'b0;
        end else if (load) begin
            s1_valid_reg <= 1'b0;
        end else if (advance) begin
            s1_q_reg     <= quadrant_t'(s0_angle_reg[PHASE_W-1 -: 2]);
            s1_valid_reg <= s0_valid_reg;
        end
    end

    // Quadrant folding: odd quadrants swap the sin/cos magnitudes, and the
    // signs follow the quadrant each component lies in.
    always_comb begin
        real_next = '0;
        imag_next = '0;
        case (s1_q_reg)
            QUAD_0: begin
                imag_next = signed_mag(lut_sin, 1'b0);
                real_next = signed_mag(lut_cos, 1'b0);
            end
            QUAD_1: begin
                imag_next = signed_mag(lut_cos, 1'b0);
                real_next = signed_mag(lut_sin, 1'b1);
            end
            QUAD_2: begin
                imag_next = signed_mag(lut_sin, 1'b1);
                real_next = signed_mag(lut_cos, 1'b1);
            end
            QUAD_3: begin
                imag_next = signed_mag(lut_cos, 1'b1);
                real_next = signed_mag(lut_sin, 1'b0);
            end
            default: begin
                imag_next = '0;
                real_next = '0;
            end
        endcase
    end

    // Stage 2: output registers; data holds while a sample waits for ready.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ph_valid_reg <= 1'b0;
            ph_real_reg  <= '0;
            ph_imag_reg  <= '0;
        end else if (load) begin
            ph_valid_reg <= 1'b0;
        end else if (advance) begin
            ph_valid_reg <= s1_valid_reg;
            ph_real_reg  <= real_next;
            ph_imag_reg  <= imag_next;
        end
    end

    assign ph_valid = ph_valid_reg;
    assign ph_real  = ph_real_reg;
    assign ph_imag  = ph_imag_reg;

endmodule : phasor_nco
